// File: rtl/csr_file_if.sv
// Execute-stage CSR access bus: request fields driven by the core (master),
// old value and illegal flag returned by the CSR file (slave).
interface csr_file_if #(
    parameter int unsigned WIDTH = 32
);
    logic             csr_valid_i;
    logic [11:0]      csr_addr_i;
    logic [1:0]       csr_control_i;
    logic             csr_write_i;
    logic [WIDTH-1:0] csr_op_a_i;
    logic             instr_retire_i;
    logic [WIDTH-1:0] csr_rdata_o;
    logic             csr_illegal_o;

    modport master (
        output csr_valid_i, csr_addr_i, csr_control_i, csr_write_i, csr_op_a_i, instr_retire_i,
        input  csr_rdata_o, csr_illegal_o
    );

    modport slave (
        input  csr_valid_i, csr_addr_i, csr_control_i, csr_write_i, csr_op_a_i, instr_retire_i,
        output csr_rdata_o, csr_illegal_o
    );
endinterface

// File: rtl/csr_file.sv
// Machine-mode CSR file: mcycle/minstret, mcountinhibit and scratch CSRs with a
// read-modify-write datapath; old value read combinationally, update commits at clk_i.
module csr_file #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned NUM_SCRATCH = 4
) (
    input  logic      clk_i,
    input  logic      reset_i,
    csr_file_if.slave bus
);
    localparam int unsigned CNT_W  = 64;
    localparam int unsigned HALF_W = 32;
    localparam int unsigned ADDR_W = 12;

    localparam logic [1:0] CSR_PASS  = 2'b01;
    localparam logic [1:0] CSR_SET   = 2'b10;
    localparam logic [1:0] CSR_CLEAR = 2'b11;

    localparam logic [ADDR_W-1:0] ADDR_MCYCLE        = 12'hB00;
    localparam logic [ADDR_W-1:0] ADDR_MINSTRET      = 12'hB02;
    localparam logic [ADDR_W-1:0] ADDR_MCYCLEH       = 12'hB80;
    localparam logic [ADDR_W-1:0] ADDR_MINSTRETH     = 12'hB82;
    localparam logic [ADDR_W-1:0] ADDR_CYCLE         = 12'hC00;
    localparam logic [ADDR_W-1:0] ADDR_INSTRET       = 12'hC02;
    localparam logic [ADDR_W-1:0] ADDR_CYCLEH        = 12'hC80;
    localparam logic [ADDR_W-1:0] ADDR_INSTRETH      = 12'hC82;
    localparam logic [ADDR_W-1:0] ADDR_MCOUNTINHIBIT = 12'h320;
    localparam logic [ADDR_W-1:0] ADDR_SCRATCH0      = 12'h7C0;

    localparam logic IS_RV32 = (WIDTH == 32);

    logic [CNT_W-1:0] mcycle_q, mcycle_d;
    logic [CNT_W-1:0] minstret_q, minstret_d;
    logic             cy_inhibit_q, cy_inhibit_d;
    logic             ir_inhibit_q, ir_inhibit_d;
    logic [WIDTH-1:0] scratch_q [NUM_SCRATCH];
    logic [WIDTH-1:0] scratch_d [NUM_SCRATCH];

    logic              sel_cycle_lo, sel_cycle_hi;
    logic              sel_instret_lo, sel_instret_hi;
    logic              sel_inhibit, sel_scratch;
    logic [ADDR_W-1:0] scratch_off;
    logic              mapped_c, ro_alias_c, illegal_c, commit_c;
    logic [WIDTH-1:0]  old_c, new_c;

    // Address decode; high-half aliases exist only on RV32.
    always_comb begin : decode
        sel_cycle_lo   = 1'b0;
        sel_cycle_hi   = 1'b0;
        sel_instret_lo = 1'b0;
        sel_instret_hi = 1'b0;
        sel_inhibit    = 1'b0;
        scratch_off    = bus.csr_addr_i - ADDR_SCRATCH0;
        sel_scratch    = (bus.csr_addr_i >= ADDR_SCRATCH0) &&
                         (scratch_off < ADDR_W'(NUM_SCRATCH));
        case (bus.csr_addr_i)
            ADDR_MCYCLE,   ADDR_CYCLE:    sel_cycle_lo   = 1'b1;
            ADDR_MINSTRET, ADDR_INSTRET:  sel_instret_lo = 1'b1;
            ADDR_MCYCLEH,  ADDR_CYCLEH:   sel_cycle_hi   = IS_RV32;
            ADDR_MINSTRETH, ADDR_INSTRETH: sel_instret_hi = IS_RV32;
            ADDR_MCOUNTINHIBIT:           sel_inhibit    = 1'b1;
            default: ;
        endcase
    end

    // Old-value mux; unimplemented mcountinhibit bits read as zero.
    always_comb begin : read_mux
        old_c = '0;
        if (sel_cycle_lo) begin
            old_c = mcycle_q[WIDTH-1:0];
        end else if (sel_cycle_hi) begin
            old_c = WIDTH'(mcycle_q[CNT_W-1:HALF_W]);
        end else if (sel_instret_lo) begin
            old_c = minstret_q[WIDTH-1:0];
        end else if (sel_instret_hi) begin
            old_c = WIDTH'(minstret_q[CNT_W-1:HALF_W]);
        end else if (sel_inhibit) begin
            old_c[0] = cy_inhibit_q;
            old_c[2] = ir_inhibit_q;
        end else if (sel_scratch) begin
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                if (scratch_off == ADDR_W'(i)) begin
                    old_c = scratch_q[i];
                end
            end
        end
    end

    always_comb begin : access_check
        mapped_c   = sel_cycle_lo | sel_cycle_hi | sel_instret_lo | sel_instret_hi |
                     sel_inhibit | sel_scratch;
        ro_alias_c = (bus.csr_addr_i[11:10] == 2'b11);
        illegal_c  = bus.csr_valid_i & (~mapped_c | (bus.csr_write_i & ro_alias_c));
        commit_c   = bus.csr_valid_i & bus.csr_write_i & ~illegal_c;
    end

    always_comb begin : modify
        case (bus.csr_control_i)
            CSR_SET:   new_c = old_c | bus.csr_op_a_i;
            CSR_CLEAR: new_c = old_c & ~bus.csr_op_a_i;
            CSR_PASS:  new_c = bus.csr_op_a_i;
            default:   new_c = bus.csr_op_a_i;
        endcase
    end

    // A committed write to either counter half replaces that edge's increment;
    // inhibit bits are sampled from the current (pre-write) value.
    always_comb begin : next_state
        mcycle_d     = mcycle_q;
        minstret_d   = minstret_q;
        cy_inhibit_d = cy_inhibit_q;
        ir_inhibit_d = ir_inhibit_q;
        scratch_d    = scratch_q;

        if (commit_c && sel_cycle_lo) begin
            mcycle_d[WIDTH-1:0] = new_c;
        end else if (commit_c && sel_cycle_hi) begin
            mcycle_d[CNT_W-1:HALF_W] = new_c[HALF_W-1:0];
        end else if (!cy_inhibit_q) begin
            mcycle_d = mcycle_q + CNT_W'(1);
        end

        if (commit_c && sel_instret_lo) begin
            minstret_d[WIDTH-1:0] = new_c;
        end else if (commit_c && sel_instret_hi) begin
            minstret_d[CNT_W-1:HALF_W] = new_c[HALF_W-1:0];
        end else if (bus.instr_retire_i && !ir_inhibit_q) begin
            minstret_d = minstret_q + CNT_W'(1);
        end

        if (commit_c && sel_inhibit) begin
            cy_inhibit_d = new_c[0];
            ir_inhibit_d = new_c[2];
        end

        for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
            if (commit_c && sel_scratch && (scratch_off == ADDR_W'(i))) begin
                scratch_d[i] = new_c;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin : state_reg
        if (reset_i) begin
            mcycle_q     <= '0;
            minstret_q   <= '0;
            cy_inhibit_q <= 1'b0;
            ir_inhibit_q <= 1'b0;
            for (int unsigned i = 0; i < NUM_SCRATCH; i++) begin
                scratch_q[i] <= '0;
            end
        end else begin
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
            cy_inhibit_q <= cy_inhibit_d;
            ir_inhibit_q <= ir_inhibit_d;
            scratch_q    <= scratch_d;
        end
    end

    assign bus.csr_rdata_o   = (bus.csr_valid_i && mapped_c) ? old_c : '0;
    assign bus.csr_illegal_o = illegal_c;
endmodule

// File: tb/tb_csr_file.sv
// Bench for csr_file: RV32 and RV64 instances driven in lockstep and checked
// against an arithmetic model of the CSR state.
module tb_csr_file;
    localparam int unsigned NS = 4;
    localparam logic [1:0] PASS = 2'b01;
    localparam logic [1:0] SET  = 2'b10;
    localparam logic [1:0] CLR  = 2'b11;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    csr_file_if #(.WIDTH(32)) if32 ();
    csr_file_if #(.WIDTH(64)) if64 ();

    csr_file #(.WIDTH(32), .NUM_SCRATCH(NS)) dut32 (.clk_i(clk), .reset_i(rst), .bus(if32));
    csr_file #(.WIDTH(64), .NUM_SCRATCH(NS)) dut64 (.clk_i(clk), .reset_i(rst), .bus(if64));

    // Model state, index 0 = RV32 instance, 1 = RV64 instance.
    logic [63:0] m_cyc [2];
    logic [63:0] m_ins [2];
    logic [63:0] m_scr [2][16];
    bit          m_cy  [2];
    bit          m_ir  [2];

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] last_rd  [2];
    logic        last_ill [2];

    logic [11:0] addrs [15] = '{12'hB00, 12'hB02, 12'hB80, 12'hB82, 12'hC00, 12'hC02,
                                12'hC80, 12'hC82, 12'h320, 12'h7C0, 12'h7C1, 12'h7C2,
                                12'h7C3, 12'h7C4, 12'h123};

    function automatic logic [63:0] wmask(input int d);
        return (d == 0) ? 64'h0000_0000_FFFF_FFFF : ONES;
    endfunction

    function automatic void m_reset();
        for (int d = 0; d < 2; d++) begin
            m_cyc[d] = '0;
            m_ins[d] = '0;
            m_cy[d]  = 1'b0;
            m_ir[d]  = 1'b0;
            for (int i = 0; i < 16; i++) m_scr[d][i] = '0;
        end
    endfunction

    function automatic void m_lookup(input int d, input logic [11:0] a,
                                     output bit mapped, output logic [63:0] val);
        int idx;
        mapped = 1'b1;
        val    = '0;
        idx    = int'(a) - 'h7C0;
        case (a)
            12'hB00, 12'hC00: val = m_cyc[d];
            12'hB02, 12'hC02: val = m_ins[d];
            12'hB80, 12'hC80: begin mapped = (d == 0); val = m_cyc[d] >> 32; end
            12'hB82, 12'hC82: begin mapped = (d == 0); val = m_ins[d] >> 32; end
            12'h320:          val = {61'd0, m_ir[d], 1'b0, m_cy[d]};
            default: begin
                mapped = (idx >= 0) && (idx < int'(NS));
                if (mapped) val = m_scr[d][idx];
            end
        endcase
        if (!mapped) val = '0;
        val = val & wmask(d);
    endfunction

    function automatic void m_update(input int d, input logic v, input logic [11:0] a,
                                     input logic [1:0] c, input logic w,
                                     input logic [63:0] op, input logic r);
        bit          mapped, commit;
        logic [63:0] old, nv, opm;
        m_lookup(d, a, mapped, old);
        commit = v && w && mapped && (a[11:10] != 2'b11);
        opm    = op & wmask(d);
        case (c)
            SET:     nv = old | opm;
            CLR:     nv = old & ~opm;
            default: nv = opm;
        endcase
        nv = nv & wmask(d);
        if (commit && a == 12'hB00)      m_cyc[d] = (d == 1) ? nv : {m_cyc[d][63:32], nv[31:0]};
        else if (commit && a == 12'hB80) m_cyc[d] = {nv[31:0], m_cyc[d][31:0]};
        else if (!m_cy[d])               m_cyc[d] = m_cyc[d] + 64'd1;
        if (commit && a == 12'hB02)      m_ins[d] = (d == 1) ? nv : {m_ins[d][63:32], nv[31:0]};
        else if (commit && a == 12'hB82) m_ins[d] = {nv[31:0], m_ins[d][31:0]};
        else if (r && !m_ir[d])          m_ins[d] = m_ins[d] + 64'd1;
        if (commit && a == 12'h320) begin
            m_cy[d] = nv[0];
            m_ir[d] = nv[2];
        end
        if (commit && a >= 12'h7C0 && int'(a) < 'h7C0 + int'(NS)) m_scr[d][int'(a) - 'h7C0] = nv;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [11:0] a, input logic [1:0] c,
                         input logic w, input logic [63:0] op, input logic r);
        if32.csr_valid_i = v;  if64.csr_valid_i = v;
        if32.csr_addr_i = a;   if64.csr_addr_i = a;
        if32.csr_control_i = c; if64.csr_control_i = c;
        if32.csr_write_i = w;  if64.csr_write_i = w;
        if32.csr_op_a_i = op[31:0]; if64.csr_op_a_i = op;
        if32.instr_retire_i = r; if64.instr_retire_i = r;
    endtask

    // One cycle: drive, check combinational outputs against the model, then advance.
    task automatic step(input logic v, input logic [11:0] a, input logic [1:0] c,
                        input logic w, input logic [63:0] op, input logic r);
        bit          mapped;
        logic [63:0] val;
        drive(v, a, c, w, op, r);
        #1;
        last_rd[0]  = 64'(if32.csr_rdata_o);
        last_rd[1]  = if64.csr_rdata_o;
        last_ill[0] = if32.csr_illegal_o;
        last_ill[1] = if64.csr_illegal_o;
        for (int d = 0; d < 2; d++) begin
            m_lookup(d, a, mapped, val);
            check($sformatf("rdata_w%0d@%h", (d == 0) ? 32 : 64, a), last_rd[d],
                  (v && mapped) ? val : 64'd0);
            check($sformatf("illegal_w%0d@%h", (d == 0) ? 32 : 64, a), 64'(last_ill[d]),
                  64'(v && (!mapped || (w && a[11:10] == 2'b11))));
        end
        @(posedge clk);
        for (int d = 0; d < 2; d++) m_update(d, v, a, c, w, op, r);
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        m_reset();
        drive(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_mcycle_w32", 64'(if32.csr_rdata_o), 64'd0);
        check("reset_mcycle_w64", if64.csr_rdata_o, 64'd0);
        drive(1'b0, 12'h7C0, PASS, 1'b0, 64'd0, 1'b0);
        #1;
        check("idle_rdata_w32", 64'(if32.csr_rdata_o), 64'd0);
        check("idle_illegal_w64", 64'(if64.csr_illegal_o), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Free-running cycle counter after reset.
        repeat (10) step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        check("t1_mcycle_w32", last_rd[0], 64'd10);
        check("t1_mcycle_w64", last_rd[1], 64'd10);
        step(1'b1, 12'hB80, SET, 1'b0, 64'd0, 1'b0);
        check("t1_mcycleh_w32", last_rd[0], 64'd0);
        check("t1_mcycleh_ill_w64", 64'(last_ill[1]), 64'd1);

        // Scratch read-modify-write.
        step(1'b1, 12'h7C1, PASS, 1'b1, 64'hDEAD_BEEF, 1'b0);
        step(1'b1, 12'h7C1, SET, 1'b1, 64'h0000_00F0, 1'b0);
        check("t2_set_old_w32", last_rd[0], 64'hDEAD_BEEF);
        check("t2_set_old_w64", last_rd[1], 64'hDEAD_BEEF);
        step(1'b1, 12'h7C1, SET, 1'b0, 64'd0, 1'b0);
        check("t2_after_set", last_rd[0], 64'hDEAD_BEFF);
        step(1'b1, 12'h7C1, CLR, 1'b1, 64'h0000_00FF, 1'b0);
        step(1'b1, 12'h7C1, SET, 1'b0, 64'd0, 1'b0);
        check("t2_after_clr_w32", last_rd[0], 64'hDEAD_BE00);
        check("t2_after_clr_w64", last_rd[1], 64'hDEAD_BE00);

        // Carry into the high half, then full 64-bit wrap.
        step(1'b1, 12'hB00, PASS, 1'b1, 64'h0000_0000_FFFF_FFFE, 1'b0);
        step(1'b1, 12'hB80, PASS, 1'b1, 64'd0, 1'b0);
        step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b0);
        step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        check("t3_carry_lo_w32", last_rd[0], 64'd0);
        step(1'b1, 12'hB80, SET, 1'b0, 64'd0, 1'b0);
        check("t3_carry_hi_w32", last_rd[0], 64'd1);
        step(1'b1, 12'hB80, PASS, 1'b1, ONES, 1'b0);
        step(1'b1, 12'hB00, PASS, 1'b1, ONES, 1'b0);
        step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        check("t3_wrap_w32", last_rd[0], 64'd0);
        check("t3_wrap_w64", last_rd[1], 64'd0);

        // Counter inhibit.
        step(1'b1, 12'h320, PASS, 1'b1, 64'hFFFF_FFFF, 1'b0);
        step(1'b1, 12'h320, SET, 1'b0, 64'd0, 1'b0);
        check("t4_inhibit_w32", last_rd[0], 64'h5);
        check("t4_inhibit_w64", last_rd[1], 64'h5);
        repeat (3) step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b1);
        step(1'b1, 12'hB02, SET, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'h320, CLR, 1'b1, 64'h5, 1'b0);
        repeat (3) step(1'b0, 12'h000, PASS, 1'b0, 64'd0, 1'b1);
        step(1'b1, 12'hB02, SET, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);

        // Illegal accesses.
        step(1'b1, 12'hC00, PASS, 1'b1, 64'h1234, 1'b0);
        check("t5_ro_write_w32", 64'(last_ill[0]), 64'd1);
        check("t5_ro_write_w64", 64'(last_ill[1]), 64'd1);
        step(1'b1, 12'hC00, SET, 1'b0, 64'd0, 1'b0);
        check("t5_ro_read_w32", 64'(last_ill[0]), 64'd0);
        step(1'b1, 12'h7C0 + 12'(NS), SET, 1'b0, 64'd0, 1'b0);
        check("t5_scratch_oob_ill", 64'(last_ill[0]), 64'd1);
        check("t5_scratch_oob_rd", last_rd[1], 64'd0);

        // Write beats retire increment.
        step(1'b1, 12'hB02, PASS, 1'b1, 64'h100, 1'b1);
        step(1'b1, 12'hB02, SET, 1'b0, 64'd0, 1'b0);
        check("t6_write_wins_w32", last_rd[0], 64'h100);
        check("t6_write_wins_w64", last_rd[1], 64'h100);

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            step(1'($urandom_range(0, 7) != 0), addrs[$urandom_range(0, 14)],
                 2'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, 1'($urandom_range(0, 1)));
        end

        // Reset in the middle of a pending write.
        drive(1'b1, 12'h7C2, PASS, 1'b1, 64'hCAFE, 1'b1);
        #2 rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        m_reset();
        rst = 1'b0;
        step(1'b1, 12'hB00, SET, 1'b0, 64'd0, 1'b0);
        check("t6_reset_mcycle_w32", last_rd[0], 64'd0);
        check("t6_reset_mcycle_w64", last_rd[1], 64'd0);
        step(1'b1, 12'h7C2, SET, 1'b0, 64'd0, 1'b0);
        check("t6_reset_scratch_w32", last_rd[0], 64'd0);
        check("t6_reset_scratch_w64", last_rd[1], 64'd0);
        step(1'b1, 12'hB02, SET, 1'b0, 64'd0, 1'b0);
        step(1'b1, 12'h320, SET, 1'b0, 64'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
